// File: rtl/sram_arbiter.sv
// sram_arbiter: 2:1 arbiter sharing one request/response memory port between instruction fetch and data access.
// Fixed data-over-instruction priority by default; define ARB_ROUND_ROBIN_EN for round-robin on contention.
module sram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                i_req,
    input  logic                i_wr,
    input  logic [1:0]          i_size,
    input  logic [DATA_W/8-1:0] i_wstrb,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    output logic                i_addr_ok,
    output logic                i_data_ok,
    output logic [DATA_W-1:0]   i_rdata,

    input  logic                d_req,
    input  logic                d_wr,
    input  logic [1:0]          d_size,
    input  logic [DATA_W/8-1:0] d_wstrb,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_addr_ok,
    output logic                d_data_ok,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                m_req,
    output logic                m_wr,
    output logic [1:0]          m_size,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_addr_ok,
    input  logic                m_data_ok,
    input  logic [DATA_W-1:0]   m_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT} state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;   // 1 = data requester owns the transaction
    logic                wr_q, wr_d;
    logic [1:0]          size_q, size_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                grant_i, grant_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q, last_d_d;               // 1 = data granted last

    always_comb begin
        grant_d = d_req && (!i_req || !last_d_q);
        grant_i = i_req && !grant_d;
        last_d_d = last_d_q;
        if (state_q == S_IDLE && (grant_i || grant_d)) last_d_d = grant_d;
    end

    always_ff @(posedge clk) begin
        if (reset) last_d_q <= 1'b0;
        else       last_d_q <= last_d_d;
    end
`else
    always_comb begin
        grant_d = d_req;
        grant_i = i_req && !d_req;
    end
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        wr_d      = wr_q;
        size_d    = size_q;
        wstrb_d   = wstrb_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_addr_ok = 1'b0;
        d_addr_ok = 1'b0;
        i_data_ok = 1'b0;
        d_data_ok = 1'b0;
        m_req     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_i || grant_d) begin
                    i_addr_ok = grant_i;
                    d_addr_ok = grant_d;
                    owner_d   = grant_d;
                    wr_d      = grant_d ? d_wr    : i_wr;
                    size_d    = grant_d ? d_size  : i_size;
                    wstrb_d   = grant_d ? d_wstrb : i_wstrb;
                    addr_d    = grant_d ? d_addr  : i_addr;
                    wdata_d   = grant_d ? d_wdata : i_wdata;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                m_req = 1'b1;
                if (m_addr_ok) state_d = S_WAIT;
            end
            S_WAIT: begin
                // A response outside WAIT is a protocol violation and is never routed.
                if (m_data_ok) begin
                    i_data_ok = !owner_q;
                    d_data_ok = owner_q;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            wstrb_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            wstrb_q <= wstrb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign m_wr    = wr_q;
    assign m_size  = size_q;
    assign m_wstrb = wstrb_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: transaction-level model checked every cycle plus directed literal checks.
// Build with ARB_ROUND_ROBIN_EN defined to exercise the round-robin variant.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0, i_wr = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [1:0]  i_size = 2'd0, d_size = 2'd0;
    logic [3:0]  i_wstrb = 4'h0, d_wstrb = 4'h0;
    logic [31:0] i_addr = '0, d_addr = '0, i_wdata = '0, d_wdata = '0;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [31:0] i_rdata, d_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok = 1'b0, m_data_ok = 1'b0;
    logic [31:0] m_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_wstrb(i_wstrb), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Transaction-level model: one outstanding transaction, issued or not yet issued downstream.
    logic        model_en = 1'b0;
    logic        tx_busy = 1'b0, tx_issued = 1'b0, tx_own_d = 1'b0, last_was_d = 1'b0;
    logic        tx_wr = 1'b0;
    logic [1:0]  tx_size = 2'd0;
    logic [3:0]  tx_wstrb = 4'h0;
    logic [31:0] tx_addr = '0, tx_wdata = '0;

    always @(negedge clk) begin
        logic prefer_d, e_daok, e_iaok, e_idok, e_ddok, e_mreq;
        if (model_en) begin
`ifdef ARB_ROUND_ROBIN_EN
            prefer_d = !last_was_d;
`else
            prefer_d = 1'b1;
`endif
            e_daok = !tx_busy && d_req && (!i_req || prefer_d);
            e_iaok = !tx_busy && i_req && !e_daok;
            e_mreq = tx_busy && !tx_issued;
            e_idok = tx_busy && tx_issued && m_data_ok && !tx_own_d;
            e_ddok = tx_busy && tx_issued && m_data_ok && tx_own_d;
            chk("mdl_m_req", m_req, e_mreq);
            chk("mdl_i_addr_ok", i_addr_ok, e_iaok);
            chk("mdl_d_addr_ok", d_addr_ok, e_daok);
            chk("mdl_i_data_ok", i_data_ok, e_idok);
            chk("mdl_d_data_ok", d_data_ok, e_ddok);
            chk("mdl_m_ctl", {m_wr, m_size, m_wstrb}, {tx_wr, tx_size, tx_wstrb});
            chk("mdl_m_addr", m_addr, tx_addr);
            chk("mdl_m_wdata", m_wdata, tx_wdata);
            if (e_idok && !tx_wr) chk("mdl_i_rdata", i_rdata, m_rdata);
            if (e_ddok && !tx_wr) chk("mdl_d_rdata", d_rdata, m_rdata);

            if (reset) begin
                tx_busy = 0; tx_issued = 0; tx_own_d = 0; last_was_d = 0;
                tx_wr = 0; tx_size = 0; tx_wstrb = 0; tx_addr = 0; tx_wdata = 0;
            end else if (e_daok || e_iaok) begin
                tx_busy    = 1;
                tx_issued  = 0;
                tx_own_d   = e_daok;
                last_was_d = e_daok;
                tx_wr    = e_daok ? d_wr    : i_wr;
                tx_size  = e_daok ? d_size  : i_size;
                tx_wstrb = e_daok ? d_wstrb : i_wstrb;
                tx_addr  = e_daok ? d_addr  : i_addr;
                tx_wdata = e_daok ? d_wdata : i_wdata;
            end else if (tx_busy && !tx_issued && m_addr_ok) begin
                tx_issued = 1;
            end else if (tx_busy && tx_issued && m_data_ok) begin
                tx_busy = 0;
            end
        end
    end

    // Entered at the start of the cycle after a grant; leaves at the start of the cycle after the response.
    task automatic downstream(input string tag, input int a_lat, input int d_lat, input logic [31:0] rd,
                              input logic [31:0] exp_addr, input logic exp_wr, input logic [1:0] exp_dok);
        for (int k = 0; k <= a_lat; k++) begin
            m_addr_ok = (k == a_lat);
            smp();
            chk({tag, "_m_req"}, m_req, 1);
            chk({tag, "_m_addr"}, m_addr, exp_addr);
            chk({tag, "_m_wr"}, m_wr, exp_wr);
            chk({tag, "_no_addr_ok"}, {i_addr_ok, d_addr_ok}, 2'b00);
            cyc();
        end
        m_addr_ok = 0;
        for (int k = 0; k < d_lat; k++) begin
            smp();
            chk({tag, "_wait_m_req"}, m_req, 0);
            chk({tag, "_wait_data_ok"}, {i_data_ok, d_data_ok}, 2'b00);
            cyc();
        end
        m_data_ok = 1;
        m_rdata   = rd;
        smp();
        chk({tag, "_data_ok"}, {i_data_ok, d_data_ok}, exp_dok);
        chk({tag, "_resp_addr_ok"}, {i_addr_ok, d_addr_ok}, 2'b00);
        if (!exp_wr) chk({tag, "_rdata"}, exp_dok[1] ? i_rdata : d_rdata, rd);
        cyc();
        m_data_ok = 0;
        m_rdata   = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic g2_d;
        repeat (2) @(posedge clk);
        #1;
        model_en = 1;
        smp();
        chk("rst_m_req", m_req, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_addr_ok", {i_addr_ok, d_addr_ok}, 2'b00);
        cyc();
        reset = 0;

        // single instruction read
        i_req = 1; i_wr = 0; i_size = 2'd2; i_wstrb = 4'hF; i_addr = 32'h1C00_0000;
        smp();
        chk("t1_i_addr_ok", i_addr_ok, 1);
        chk("t1_d_addr_ok", d_addr_ok, 0);
        cyc();
        i_req = 0;
        downstream("t1", 0, 0, 32'h0280_0C0C, 32'h1C00_0000, 0, 2'b10);

        // spurious response while idle
        m_data_ok = 1; m_rdata = 32'h5555_AAAA;
        smp();
        chk("t6_data_ok", {i_data_ok, d_data_ok}, 2'b00);
        chk("t6_m_req", m_req, 0);
        cyc();
        m_data_ok = 0;
        i_req = 1; i_addr = 32'h1C00_0004;
        smp();
        chk("t6_still_idle", i_addr_ok, 1);
        cyc();
        i_req = 0;
        downstream("t6", 0, 0, 32'h1234_5678, 32'h1C00_0004, 0, 2'b10);

        // contention, one-shot requesters
        d_req = 1; d_wr = 1; d_size = 2'd2; d_wstrb = 4'hF; d_addr = 32'h0000_1000; d_wdata = 32'hDEAD_BEEF;
        i_req = 1; i_addr = 32'h1C00_0008;
        smp();
        chk("t2_d_first", {i_addr_ok, d_addr_ok}, 2'b01);
        cyc();
        d_req = 0;
        smp();
        chk("t2_m_wdata", m_wdata, 32'hDEAD_BEEF);
        cyc();
        m_addr_ok = 1;
        smp();
        cyc();
        m_addr_ok = 0;
        m_data_ok = 1;
        smp();
        chk("t2_d_data_ok", {i_data_ok, d_data_ok}, 2'b01);
        cyc();
        m_data_ok = 0;
        smp();
        chk("t2_i_second", {i_addr_ok, d_addr_ok}, 2'b10);
        cyc();
        i_req = 0;
        downstream("t2i", 0, 0, 32'h1111_2222, 32'h1C00_0008, 0, 2'b10);

        // contention, both requesters held across three grants
        d_req = 1; d_wr = 0; d_addr = 32'h0000_2000;
        i_req = 1; i_addr = 32'h1C00_000C;
        smp();
        chk("t2b_g1", {i_addr_ok, d_addr_ok}, 2'b01);
        cyc();
        downstream("t2b1", 0, 0, 32'hA1A1_A1A1, 32'h0000_2000, 0, 2'b01);
`ifdef ARB_ROUND_ROBIN_EN
        g2_d = 0;
`else
        g2_d = 1;
`endif
        smp();
        chk("t2b_g2", {i_addr_ok, d_addr_ok}, g2_d ? 2'b01 : 2'b10);
        cyc();
        downstream("t2b2", 0, 0, 32'hB2B2_B2B2, g2_d ? 32'h0000_2000 : 32'h1C00_000C, 0, g2_d ? 2'b01 : 2'b10);
        smp();
        chk("t2b_g3", {i_addr_ok, d_addr_ok}, 2'b01);
        cyc();
        d_req = 0; i_req = 0;
        downstream("t2b3", 0, 0, 32'hC3C3_C3C3, 32'h0000_2000, 0, 2'b01);

        // downstream address stall with a waiting instruction request
        d_req = 1; d_wr = 1; d_addr = 32'h0000_3000; d_wdata = 32'hCAFE_F00D;
        smp();
        chk("t3_d_addr_ok", d_addr_ok, 1);
        cyc();
        d_req = 0;
        i_req = 1; i_addr = 32'h1C00_0010;
        downstream("t3", 5, 0, 32'h0, 32'h0000_3000, 1, 2'b01);
        smp();
        chk("t3_i_after", i_addr_ok, 1);
        cyc();
        i_req = 0;
        downstream("t3i", 0, 0, 32'h3333_4444, 32'h1C00_0010, 0, 2'b10);

        // long response latency with a data request arriving during WAIT
        i_req = 1; i_addr = 32'h1C00_0014;
        smp();
        chk("t4_i_addr_ok", i_addr_ok, 1);
        cyc();
        i_req = 0; m_addr_ok = 1;
        smp();
        cyc();
        m_addr_ok = 0;
        d_req = 1; d_wr = 0; d_addr = 32'h0000_4000;
        for (int k = 0; k < 10; k++) begin
            smp();
            chk("t4_wait_d_addr_ok", d_addr_ok, 0);
            chk("t4_wait_i_data_ok", i_data_ok, 0);
            cyc();
        end
        m_data_ok = 1; m_rdata = 32'h4444_5555;
        smp();
        chk("t4_i_data_ok", i_data_ok, 1);
        chk("t4_i_rdata", i_rdata, 32'h4444_5555);
        chk("t4_d_addr_ok_resp", d_addr_ok, 0);
        cyc();
        m_data_ok = 0; m_rdata = '0;
        smp();
        chk("t4_d_granted", d_addr_ok, 1);
        cyc();
        d_req = 0;
        downstream("t4d", 0, 0, 32'h5555_6666, 32'h0000_4000, 0, 2'b01);

        // reset during WAIT
        i_req = 1; i_addr = 32'h1C00_0018;
        smp();
        chk("t5_i_addr_ok", i_addr_ok, 1);
        cyc();
        i_req = 0; m_addr_ok = 1;
        smp();
        cyc();
        m_addr_ok = 0;
        reset = 1;
        smp();
        cyc();
        reset = 0;
        m_data_ok = 1; m_rdata = 32'h7777_8888;
        smp();
        chk("t5_m_req", m_req, 0);
        chk("t5_data_ok", {i_data_ok, d_data_ok}, 2'b00);
        chk("t5_m_addr", m_addr, 0);
        cyc();
        m_data_ok = 0; m_rdata = '0;
        i_req = 1; i_addr = 32'h1C00_001C;
        smp();
        chk("t5_fresh_grant", i_addr_ok, 1);
        cyc();
        i_req = 0;
        downstream("t5", 0, 0, 32'h9999_AAAA, 32'h1C00_001C, 0, 2'b10);

        repeat (2) cyc();
        model_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-to-one arbiter sharing a single request/response memory port between the instruction-fetch requester and the data-access requester of the five-stage pipeline. Sits between the IF/MEM stages and the memory-side bridge. Accepts one transaction at a time, latches it, drives it downstream, and routes the response back to its owner. Fixed data-over-instruction priority by default; round-robin selectable at compile time.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (wstrb width = DATA_W/8)

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req / d_req  in  1  instruction / data requester has a request
- i_wr / d_wr  in  1  1 = write
- i_size / d_size  in  2  0 byte, 1 half, 2 word
- i_wstrb / d_wstrb  in  DATA_W/8  byte enables
- i_addr / d_addr  in  ADDR_W  address
- i_wdata / d_wdata  in  DATA_W  write data
- i_addr_ok / d_addr_ok  out  1  request accepted this cycle
- i_data_ok / d_data_ok  out  1  response for this requester this cycle
- i_rdata / d_rdata  out  DATA_W  read data, valid with *_data_ok
- m_req  out  1  downstream request valid
- m_wr, m_size, m_wstrb, m_addr, m_wdata  out  1/2/DATA_W/8/ADDR_W/DATA_W  latched request fields
- m_addr_ok  in  1  downstream accepted request
- m_data_ok  in  1  downstream response
- m_rdata  in  DATA_W  downstream read data

## Operation
- States: IDLE, ADDR, WAIT. One-hot or binary, implementer's choice.
- IDLE: if any req, select winner; assert winner's *_addr_ok combinationally in the same cycle; latch wr/size/wstrb/addr/wdata and owner flag; go ADDR. No req: stay.
- Arbitration (default): d_req wins whenever asserted; i_req wins only if d_req = 0.
- ADDR: m_req = 1 with latched fields held stable; on m_addr_ok go WAIT, else stay.
- WAIT: m_req = 0; on m_data_ok assert owner's *_data_ok and pass m_rdata to owner's *_rdata in the same cycle; go IDLE. Non-owner *_data_ok stays 0.
- *_addr_ok never asserted outside IDLE; at most one *_addr_ok and one *_data_ok high per cycle.
- i_rdata/d_rdata = m_rdata combinationally (value meaningful only with *_data_ok).
- m_data_ok arriving in IDLE or ADDR is ignored (protocol violation; no output effect).
- Writes follow the same path; *_data_ok signals write completion, rdata undefined.

## Timing
- Reset values: state IDLE; m_req 0; latched m_wr 0, m_size 0, m_wstrb 0, m_addr 0, m_wdata 0; owner = inst; i/d_addr_ok 0 and i/d_data_ok 0 (given req 0); round-robin pointer (if built) = data-first.
- Minimum latency: req/addr_ok cycle 0, m_req cycle 1 with m_addr_ok, m_data_ok/owner data_ok cycle 2; next grant no earlier than cycle 3.
- Downstream stall in ADDR or WAIT holds state indefinitely; requesters see no addr_ok meanwhile.
- Simultaneous i_req and d_req in IDLE: exactly one granted per arbitration rule; loser must hold req.
- Reset mid-transaction: state forced to IDLE, m_req 0 at the next edge; in-flight transaction abandoned (downstream reset together with this block).

## Configuration
- ARB_ROUND_ROBIN_EN defined: 1-bit last-grant register; on simultaneous requests, grant the requester not granted last; single requester always granted; pointer updated on each grant, reset to "inst granted last" (data first).
- Not defined: fixed priority, data always wins; no pointer register.

## Test plan
- Single i_req read addr 0x1C000000, m_addr_ok cycle 1, m_data_ok cycle 2 with m_rdata 0x02800C0C -> i_addr_ok cycle 0, i_data_ok cycle 2 with i_rdata 0x02800C0C, d_data_ok 0.
- i_req and d_req both held, d write addr 0x00001000 wdata 0xDEADBEEF wstrb 0xF -> default: d granted first, m_wr 1, m_addr 0x1000; i granted after d_data_ok; with ARB_ROUND_ROBIN_EN: d then i then d alternating.
- m_addr_ok held low 5 cycles -> m_req high and m_addr stable all 5 cycles, no *_addr_ok during stall.
- m_data_ok delayed 10 cycles in WAIT, new d_req meanwhile -> no d_addr_ok until IDLE; granted the cycle after owner's data_ok.
- Reset asserted in WAIT -> next cycle m_req 0, state IDLE, no *_data_ok; fresh i_req then completes normally.
- Spurious m_data_ok in IDLE -> both *_data_ok stay 0, state unchanged.
